pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC write enable and redirect. Handles four conditions: load-use hazards, taken branches, multi-cycle data-memory waits, and an external halt/drain/resume request. It sits beside the pipeline registers in the CPU top level and owns all of their stall and flush inputs.

---
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources, memory handshake, halt control and
// the stall/flush/PC controls the controller drives back into the pipeline.
interface pipeline_hazard_ctrl_if;
    logic [2:0] i_id_rs1_addr;
    logic [2:0] i_id_rs2_addr;
    logic       i_id_uses_rs1;
    logic       i_id_uses_rs2;
    logic       i_ex_load;
    logic       i_ex_reg_write;
    logic [2:0] i_ex_dest_addr;
    logic       i_ex_branch_taken;
    logic [7:0] i_ex_branch_target;
    logic       i_mem_req;
    logic       i_mem_ready;
    logic       i_halt_req;
    logic       i_resume;

    logic       o_stall_if_id;
    logic       o_stall_id_ex;
    logic       o_stall_ex_mem;
    logic       o_stall_mem_wb;
    logic       o_flush_if_id;
    logic       o_flush_id_ex;
    logic       o_flush_ex_mem;
    logic       o_flush_mem_wb;
    logic       o_pc_write_en;
    logic       o_pc_redirect;
    logic [7:0] o_pc_redirect_target;
    logic       o_halted;
    logic       o_mem_timeout;
    logic [2:0] o_state_out;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
               i_ex_load, i_ex_reg_write, i_ex_dest_addr, i_ex_branch_taken,
               i_ex_branch_target, i_mem_req, i_mem_ready, i_halt_req, i_resume,
        input  o_stall_if_id, o_stall_id_ex, o_stall_ex_mem, o_stall_mem_wb,
               o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb,
               o_pc_write_en, o_pc_redirect, o_pc_redirect_target, o_halted,
               o_mem_timeout, o_state_out
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
               i_ex_load, i_ex_reg_write, i_ex_dest_addr, i_ex_branch_taken,
               i_ex_branch_target, i_mem_req, i_mem_ready, i_halt_req, i_resume,
        output o_stall_if_id, o_stall_id_ex, o_stall_ex_mem, o_stall_mem_wb,
               o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb,
               o_pc_write_en, o_pc_redirect, o_pc_redirect_target, o_halted,
               o_mem_timeout, o_state_out
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (load-use, branch, memory wait, halt/drain).
// Defining HAZARD_PERF_CNT_EN adds saturating load-use / mem-wait / redirect counters.
// state | meaning: RUN normal issue | LU_STALL extra load-use bubbles | MEM_WAIT hold for data memory | DRAIN bubble out before halt | HALTED frozen until resume
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 15,
    parameter int DRAIN_CYCLES     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]          o_perf_lu_cycles,
    output logic [15:0]          o_perf_mem_cycles,
    output logic [15:0]          o_perf_flush_count
`endif
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    // Down-counters reload so that reaching zero marks the last cycle of each phase.
    localparam logic [7:0] LU_RELOAD = 8'((LOAD_USE_BUBBLES > 1) ? LOAD_USE_BUBBLES - 2 : 0);
    localparam logic [7:0] MW_RELOAD = 8'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [7:0] DR_RELOAD = 8'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t     r_state, w_next_state;
    logic [7:0] r_cnt, w_next_cnt;
    logic       r_mem_timeout, w_set_timeout;
    logic       w_lu_hazard, w_mem_wait, w_run_eval, w_allow_mw, w_lu_active;
    logic [3:0] w_stall, w_flush;
    logic       w_pc_write_en, w_pc_redirect, w_halted;

    assign w_lu_hazard = bus.i_ex_load & bus.i_ex_reg_write &
                         ((bus.i_id_uses_rs1 & (bus.i_id_rs1_addr == bus.i_ex_dest_addr)) |
                          (bus.i_id_uses_rs2 & (bus.i_id_rs2_addr == bus.i_ex_dest_addr)));
    assign w_mem_wait  = bus.i_mem_req & ~bus.i_mem_ready;

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_set_timeout = 1'b0;
        w_stall       = 4'b0000;
        w_flush       = 4'b0000;
        w_pc_write_en = 1'b1;
        w_pc_redirect = 1'b0;
        w_halted      = 1'b0;
        w_lu_active   = 1'b0;
        w_run_eval    = 1'b0;
        w_allow_mw    = 1'b1;

        case (r_state)
            ST_RUN: w_run_eval = 1'b1;
            ST_LU_STALL: begin
                if (w_mem_wait) begin
                    w_stall = 4'b0111; w_flush = 4'b1000; w_pc_write_en = 1'b0;
                    w_next_state = ST_MEM_WAIT; w_next_cnt = MW_RELOAD;
                end else begin
                    w_stall = 4'b0001; w_flush = 4'b0010; w_pc_write_en = 1'b0;
                    w_lu_active = 1'b1;
                    if (r_cnt == 8'd0) w_next_state = ST_RUN;
                    else               w_next_cnt = r_cnt - 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.i_mem_ready || r_cnt == 8'd0) begin
                    w_set_timeout = ~bus.i_mem_ready;
                    w_run_eval    = 1'b1;
                    w_allow_mw    = 1'b0;
                end else begin
                    w_stall = 4'b0111; w_flush = 4'b1000; w_pc_write_en = 1'b0;
                    w_next_cnt = r_cnt - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (w_mem_wait) begin
                    w_stall = 4'b0111; w_flush = 4'b1000; w_pc_write_en = 1'b0;
                    w_next_state = ST_MEM_WAIT; w_next_cnt = MW_RELOAD;
                end else begin
                    w_stall = 4'b0001; w_flush = 4'b0010; w_pc_write_en = 1'b0;
                    if (r_cnt == 8'd0) w_next_state = ST_HALTED;
                    else               w_next_cnt = r_cnt - 8'd1;
                end
            end
            ST_HALTED: begin
                w_stall = 4'b1111; w_pc_write_en = 1'b0; w_halted = 1'b1;
                if (bus.i_resume) w_next_state = ST_RUN;
            end
            default: w_next_state = ST_RUN;
        endcase

        if (w_run_eval) begin
            if (w_allow_mw && w_mem_wait) begin
                w_stall = 4'b0111; w_flush = 4'b1000; w_pc_write_en = 1'b0;
                w_next_state = ST_MEM_WAIT; w_next_cnt = MW_RELOAD;
            end else if (bus.i_ex_branch_taken) begin
                w_flush = 4'b0011; w_pc_redirect = 1'b1;
                w_next_state = ST_RUN;
            end else if (w_lu_hazard) begin
                w_stall = 4'b0001; w_flush = 4'b0010; w_pc_write_en = 1'b0;
                w_lu_active = 1'b1;
                if (LOAD_USE_BUBBLES > 1) begin
                    w_next_state = ST_LU_STALL; w_next_cnt = LU_RELOAD;
                end else begin
                    w_next_state = ST_RUN;
                end
            end else if (bus.i_halt_req) begin
                w_stall = 4'b0001; w_flush = 4'b0010; w_pc_write_en = 1'b0;
                w_next_state = ST_DRAIN; w_next_cnt = DR_RELOAD;
            end else begin
                w_next_state = ST_RUN;
            end
            // A memory release always returns to RUN, whatever the release cycle asked for.
            if (r_state == ST_MEM_WAIT) w_next_state = ST_RUN;
        end

        if (rst) begin
            w_stall       = 4'b0000;
            w_flush       = 4'b0000;
            w_pc_write_en = 1'b0;
            w_pc_redirect = 1'b0;
            w_halted      = 1'b0;
            w_lu_active   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_cnt         <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_set_timeout) r_mem_timeout <= 1'b1;
        end
    end

    assign bus.o_stall_if_id        = w_stall[0];
    assign bus.o_stall_id_ex        = w_stall[1];
    assign bus.o_stall_ex_mem       = w_stall[2];
    assign bus.o_stall_mem_wb       = w_stall[3];
    assign bus.o_flush_if_id        = w_flush[0];
    assign bus.o_flush_id_ex        = w_flush[1];
    assign bus.o_flush_ex_mem       = w_flush[2];
    assign bus.o_flush_mem_wb       = w_flush[3];
    assign bus.o_pc_write_en        = w_pc_write_en;
    assign bus.o_pc_redirect        = w_pc_redirect;
    assign bus.o_pc_redirect_target = w_pc_redirect ? bus.i_ex_branch_target : 8'h00;
    assign bus.o_halted             = w_halted;
    assign bus.o_mem_timeout        = r_mem_timeout;
    assign bus.o_state_out          = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_perf_lu, r_perf_mem, r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_lu    <= 16'd0;
            r_perf_mem   <= 16'd0;
            r_perf_flush <= 16'd0;
        end else begin
            if (w_lu_active && r_perf_lu != 16'hFFFF)                r_perf_lu    <= r_perf_lu + 16'd1;
            if (r_state == ST_MEM_WAIT && r_perf_mem != 16'hFFFF)    r_perf_mem   <= r_perf_mem + 16'd1;
            if (w_pc_redirect && r_perf_flush != 16'hFFFF)           r_perf_flush <= r_perf_flush + 16'd1;
        end
    end

    assign o_perf_lu_cycles   = r_perf_lu;
    assign o_perf_mem_cycles  = r_perf_mem;
    assign o_perf_flush_count = r_perf_flush;
`else
    logic w_unused_lu_active;
    assign w_unused_lu_active = w_lu_active;
`endif

endmodule
